// File: rtl/cr16_alu_exec_pkg.sv
// Shared definitions for the CR16 execute stage: widths, opcode encodings,
// PSR flag bit indices, FSM state encoding, result payload and the
// single-cycle ALU evaluation function.
// The optional iterative multiply is enabled by defining CR16_ALU_MUL_EN.
package cr16_alu_exec_pkg;

    localparam int unsigned DW        = 16;
    localparam int unsigned SUM_W     = DW + 1;
    localparam int unsigned OPC_W     = 4;
    localparam int unsigned FLAGS_W   = 5;
    localparam int unsigned SHAMT_W   = 5;
    localparam int unsigned MUL_STEPS = 16;
    localparam int unsigned CNT_W     = 5;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADDU = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADDC = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h3;
    localparam logic [OPC_W-1:0] OP_SUBC = 4'h4;
    localparam logic [OPC_W-1:0] OP_CMP  = 4'h5;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h6;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h7;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h8;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'h9;
    localparam logic [OPC_W-1:0] OP_LSH  = 4'hA;
    localparam logic [OPC_W-1:0] OP_ASHU = 4'hB;
    localparam logic [OPC_W-1:0] OP_LUI  = 4'hC;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'hD;

    localparam int unsigned FLAG_C = 4;
    localparam int unsigned FLAG_L = 3;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 0;

`ifdef CR16_ALU_MUL_EN
    typedef enum logic {ST_IDLE = 1'b0, ST_MUL_BUSY = 1'b1} state_e;
`else
    typedef enum logic {ST_IDLE = 1'b0} state_e;
`endif

    typedef struct packed {
        logic [DW-1:0]      dest;
        logic               wb;
        logic               illegal;
        logic [FLAGS_W-1:0] psr;
    } alu_res_t;

    // Single-cycle result and next PSR; MUL and unknown opcodes come back illegal.
    function automatic alu_res_t alu_compute(input logic [OPC_W-1:0]   opcode,
                                             input logic [DW-1:0]      a,
                                             input logic [DW-1:0]      b,
                                             input logic [FLAGS_W-1:0] psr);
        alu_res_t             r;
        logic [SUM_W-1:0]     sum;
        logic                 cin;
        logic [SHAMT_W-1:0]   shamt;
        logic [SHAMT_W-1:0]   nshamt;
        r.dest    = '0;
        r.wb      = 1'b1;
        r.illegal = 1'b0;
        r.psr     = psr;
        sum       = '0;
        cin       = 1'b0;
        shamt     = b[SHAMT_W-1:0];
        nshamt    = ~shamt + SHAMT_W'(1);
        case (opcode)
            OP_ADD, OP_ADDU, OP_ADDC: begin
                cin   = (opcode == OP_ADDC) && psr[FLAG_C];
                sum   = SUM_W'(a) + SUM_W'(b) + SUM_W'(cin);
                r.dest = sum[DW-1:0];
                r.psr[FLAG_C] = sum[DW];
                if (opcode != OP_ADDU)
                    r.psr[FLAG_F] = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
            end
            OP_SUB, OP_SUBC: begin
                // Bit DW of the widened difference is set exactly on borrow.
                cin   = (opcode == OP_SUBC) && psr[FLAG_C];
                sum   = SUM_W'(a) - SUM_W'(b) - SUM_W'(cin);
                r.dest = sum[DW-1:0];
                r.psr[FLAG_C] = sum[DW];
                r.psr[FLAG_F] = (a[DW-1] != b[DW-1]) && (sum[DW-1] != a[DW-1]);
            end
            OP_CMP: begin
                r.wb = 1'b0;
                r.psr[FLAG_Z] = (a == b);
                r.psr[FLAG_L] = (a < b);
                r.psr[FLAG_N] = ($signed(a) < $signed(b));
            end
            OP_AND: r.dest = a & b;
            OP_OR:  r.dest = a | b;
            OP_XOR: r.dest = a ^ b;
            OP_MOV: r.dest = b;
            OP_LSH, OP_ASHU: begin
                // Negative amounts shift right by up to 16; 16 empties or sign-fills.
                if (!shamt[SHAMT_W-1])
                    r.dest = a << shamt[SHAMT_W-2:0];
                else if (opcode == OP_ASHU)
                    r.dest = $unsigned($signed(a) >>> nshamt);
                else
                    r.dest = a >> nshamt;
            end
            OP_LUI: r.dest = {b[7:0], 8'h00};
            default: begin
                r.wb      = 1'b0;
                r.illegal = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cr16_alu_exec_if.sv
// Request/result handshake bundle between the operation requester plus
// write-back stage (master) and the execute stage (slave).
// Signals: I_valid/O_ready request handshake, I_opcode/I_op1/I_op2 payload,
// O_valid/I_ready result handshake, O_dest/O_wb/O_illegal result, O_flags PSR.
interface cr16_alu_exec_if;
    import cr16_alu_exec_pkg::*;

    logic               I_valid;
    logic               O_ready;
    logic [OPC_W-1:0]   I_opcode;
    logic [DW-1:0]      I_op1;
    logic [DW-1:0]      I_op2;
    logic               O_valid;
    logic               I_ready;
    logic [DW-1:0]      O_dest;
    logic               O_wb;
    logic               O_illegal;
    logic [FLAGS_W-1:0] O_flags;

    modport master (
        output I_valid, I_opcode, I_op1, I_op2, I_ready,
        input  O_ready, O_valid, O_dest, O_wb, O_illegal, O_flags
    );

    modport slave (
        input  I_valid, I_opcode, I_op1, I_op2, I_ready,
        output O_ready, O_valid, O_dest, O_wb, O_illegal, O_flags
    );

endinterface

// File: rtl/cr16_mul_seq.sv
// Iterative unsigned shift-add multiplier, low 16 bits of a 16x16 product.
// Ports: clk, rst (sync active-high), start loads operands, op_a/op_b,
// done_c (combinational, high the cycle after the 16th step), product.
module cr16_mul_seq
    import cr16_alu_exec_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    output logic          done_c,
    output logic [DW-1:0] product
);

    logic [DW-1:0]    acc;
    logic [DW-1:0]    mcand;
    logic [DW-1:0]    mplier;
    logic [CNT_W-1:0] cnt;
    logic             busy;

    // One partial product per cycle; busy drops the cycle done_c is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
            cnt    <= CNT_W'(MUL_STEPS);
            busy   <= 1'b1;
        end else if (busy) begin
            if (cnt != '0) begin
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CNT_W'(1);
            end else begin
                busy   <= 1'b0;
            end
        end
    end

    assign done_c  = busy && (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/cr16_alu_exec.sv
// CR16 registered execute stage: one ALU op per handshake, 1-cycle latency,
// owns the PSR {C,L,F,Z,N}. Define CR16_ALU_MUL_EN to enable the iterative
// MUL (opcode D, result 17 cycles after accept); otherwise D is illegal.
// Ports: I_clk, I_rst (sync active-high), bus (slave side of cr16_alu_exec_if).
module cr16_alu_exec
    import cr16_alu_exec_pkg::*;
#(
    parameter int unsigned        DATA_WIDTH = 16,
    parameter logic [FLAGS_W-1:0] PSR_RESET  = 5'b00000
) (
    input  logic            I_clk,
    input  logic            I_rst,
    cr16_alu_exec_if.slave  bus
);

    state_e                 state;
    state_e                 state_nxt;
    logic                   ready;
    logic                   accept;
    logic                   retire;
    logic                   is_mul;
    logic                   mul_done;
    logic [DW-1:0]          mul_product;
    logic [FLAGS_W-1:0]     psr;
    alu_res_t               res;
    logic [DATA_WIDTH-1:0]  alu_dest;

    assign accept = bus.I_valid && ready;
    assign retire = bus.O_valid && bus.I_ready;

`ifdef CR16_ALU_MUL_EN
    assign is_mul = (bus.I_opcode == OP_MUL);

    cr16_mul_seq u_mul (
        .clk     (I_clk),
        .rst     (I_rst),
        .start   (accept && is_mul),
        .op_a    (bus.I_op1),
        .op_b    (bus.I_op2),
        .done_c  (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul      = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    // State register.
    always_ff @(posedge I_clk) begin
        if (I_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state and request ready (ready follows I_ready combinationally).
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = !bus.O_valid || bus.I_ready;
`ifdef CR16_ALU_MUL_EN
                if (bus.I_valid && ready && is_mul) state_nxt = ST_MUL_BUSY;
`endif
            end
`ifdef CR16_ALU_MUL_EN
            ST_MUL_BUSY: begin
                if (mul_done) state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb res = alu_compute(bus.I_opcode, bus.I_op1, bus.I_op2, psr);
    assign alu_dest = res.dest;

    // Output register and PSR; a MUL accept only retires the pending result.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            bus.O_valid   <= 1'b0;
            bus.O_dest    <= '0;
            bus.O_wb      <= 1'b0;
            bus.O_illegal <= 1'b0;
            psr           <= PSR_RESET;
        end else if (mul_done) begin
            bus.O_valid   <= 1'b1;
            bus.O_dest    <= mul_product;
            bus.O_wb      <= 1'b1;
            bus.O_illegal <= 1'b0;
        end else if (accept && !is_mul) begin
            bus.O_valid   <= 1'b1;
            bus.O_dest    <= alu_dest;
            bus.O_wb      <= res.wb;
            bus.O_illegal <= res.illegal;
            psr           <= res.psr;
        end else if (retire) begin
            bus.O_valid   <= 1'b0;
        end
    end

    assign bus.O_ready = ready;
    assign bus.O_flags = psr;

endmodule

// File: tb/tb_cr16_alu_exec.sv
// Scoreboard bench for cr16_alu_exec: directed ops push hand-computed
// results; a negedge monitor pops and compares on every retire.
module tb_cr16_alu_exec;
    import cr16_alu_exec_pkg::*;

    typedef struct packed {
        logic [15:0] dest;
        logic        wb;
        logic        ill;
        logic [4:0]  flags;
    } exp_t;

    logic I_clk = 1'b0;
    logic I_rst;
    always #5 I_clk = ~I_clk;

    cr16_alu_exec_if bus();

    cr16_alu_exec #(.DATA_WIDTH(16), .PSR_RESET(5'b00000)) dut (
        .I_clk (I_clk),
        .I_rst (I_rst),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge I_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] d, input logic wb, input logic ill,
                                input logic [4:0] f);
        exp_t e;
        e.dest = d; e.wb = wb; e.ill = ill; e.flags = f;
        return e;
    endfunction

    // Monitor: every retire must match the oldest expected result.
    always @(negedge I_clk) begin
        if (!I_rst && bus.O_valid && bus.I_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got dest %h with no expected entry", bus.O_dest);
            end else begin
                mon_e = sb.pop_front();
                chk("dest",    bus.O_dest,             mon_e.dest);
                chk("wb",      16'(bus.O_wb),          16'(mon_e.wb));
                chk("illegal", 16'(bus.O_illegal),     16'(mon_e.ill));
                chk("flags",   16'(bus.O_flags),       16'(mon_e.flags));
            end
        end
    end

    // Issue one op; waits (bounded) for acceptance and records the expectation.
    task automatic send(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                        input exp_t e, input bit push);
        int n;
        bit rdy;
        bit done;
        bus.I_valid  = 1'b1;
        bus.I_opcode = opc;
        bus.I_op1    = a;
        bus.I_op2    = b;
        n    = 0;
        done = 1'b0;
        while (!done && n < 50) begin
            @(negedge I_clk);
            rdy = bus.O_ready;
            @(posedge I_clk);
            if (rdy) begin
                done = 1'b1;
                if (push) sb.push_back(e);
            end
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: opcode %h not accepted in %0d cycles", opc, n);
        end
        #1;
        bus.I_valid = 1'b0;
    endtask

    task automatic op(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] d, input logic [4:0] f);
        send(opc, a, b, mk(d, 1'b1, 1'b0, f), 1'b1);
    endtask

    initial begin
        int n;
        int c0;
        bit bad;
        I_rst        = 1'b1;
        bus.I_valid  = 1'b0;
        bus.I_opcode = '0;
        bus.I_op1    = '0;
        bus.I_op2    = '0;
        bus.I_ready  = 1'b1;
        repeat (3) @(posedge I_clk);
        #1 I_rst = 1'b0;

        chk("rst_valid",   16'(bus.O_valid),   16'h0);
        chk("rst_dest",    bus.O_dest,         16'h0000);
        chk("rst_wb",      16'(bus.O_wb),      16'h0);
        chk("rst_illegal", 16'(bus.O_illegal), 16'h0);
        chk("rst_flags",   16'(bus.O_flags),   16'h0);
        chk("rst_ready",   16'(bus.O_ready),   16'h1);

        // Add with signed overflow, then carry chaining into ADDC.
        op(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 5'b00100);
        chk("lat1_valid", 16'(bus.O_valid), 16'h1);
        chk("lat1_dest",  bus.O_dest,       16'h8000);
        op(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 5'b10000);
        op(OP_ADDC, 16'h0001, 16'h0001, 16'h0003, 5'b00000);

        // Compares: no write-back, Z/L/N only.
        send(OP_CMP, 16'h0005, 16'hFFFB, mk(16'h0000, 1'b0, 1'b0, 5'b01000), 1'b1);
        send(OP_CMP, 16'hFFFB, 16'h0005, mk(16'h0000, 1'b0, 1'b0, 5'b00001), 1'b1);
        send(OP_CMP, 16'h1234, 16'h1234, mk(16'h0000, 1'b0, 1'b0, 5'b00010), 1'b1);

        // Backpressure: result held, request stalled.
        op(OP_ADD, 16'h0001, 16'h0002, 16'h0003, 5'b00010);
        bus.I_ready  = 1'b0;
        bus.I_valid  = 1'b1;
        bus.I_opcode = OP_ADD;
        bus.I_op1    = 16'h0010;
        bus.I_op2    = 16'h0020;
        for (int i = 0; i < 5; i++) begin
            @(negedge I_clk);
            chk("bp_ready", 16'(bus.O_ready), 16'h0);
            chk("bp_valid", 16'(bus.O_valid), 16'h1);
            chk("bp_dest",  bus.O_dest,       16'h0003);
        end
        @(posedge I_clk);
        #1 bus.I_ready = 1'b1;
        op(OP_ADD, 16'h0010, 16'h0020, 16'h0030, 5'b00010);

        // Streaming: four ops in four cycles.
        c0 = cyc;
        for (int i = 1; i <= 4; i++)
            op(OP_ADD, 16'(i), 16'(i), 16'(2 * i), 5'b00010);
        chk("stream_cycles", 16'(cyc - c0), 16'd4);

        // Shifts and illegal opcodes.
        op(OP_LSH,  16'h0001, 16'h000F, 16'h8000, 5'b00010);
        op(OP_LSH,  16'h8000, 16'h001F, 16'h4000, 5'b00010);
        op(OP_ASHU, 16'h8000, 16'h0011, 16'hFFFF, 5'b00010);
        op(OP_LSH,  16'hFFFF, 16'h0010, 16'h0000, 5'b00010);
        op(OP_ASHU, 16'h8000, 16'h0010, 16'hFFFF, 5'b00010);
        op(OP_ASHU, 16'h4001, 16'h0002, 16'h0004, 5'b00010);
        send(4'hF, 16'h1234, 16'h5678, mk(16'h0000, 1'b0, 1'b1, 5'b00010), 1'b1);
        send(4'hE, 16'hFFFF, 16'hFFFF, mk(16'h0000, 1'b0, 1'b1, 5'b00010), 1'b1);

        // Subtract with borrow chaining, logic ops, MOV, LUI, ADDU.
        op(OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 5'b10010);
        op(OP_SUBC, 16'h0005, 16'h0001, 16'h0003, 5'b00010);
        op(OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 5'b00110);
        op(OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00110);
        op(OP_OR,   16'hF0F0, 16'h0FF0, 16'hFFF0, 5'b00110);
        op(OP_XOR,  16'hF0F0, 16'h0FF0, 16'hFF00, 5'b00110);
        op(OP_MOV,  16'h0000, 16'hABCD, 16'hABCD, 5'b00110);
        op(OP_LUI,  16'h0000, 16'h12AB, 16'hAB00, 5'b00110);
        op(OP_ADDU, 16'hFFFF, 16'h0002, 16'h0001, 5'b10110);

`ifdef CR16_ALU_MUL_EN
        op(OP_MUL, 16'h0012, 16'h0034, 16'h03A8, 5'b10110);
        n   = 0;
        bad = 1'b0;
        while (!bus.O_valid && n < 40) begin
            if (bus.O_ready) bad = 1'b1;
            @(posedge I_clk);
            #1;
            n++;
        end
        chk("mul_latency",    16'(n),   16'd17);
        chk("mul_busy_ready", 16'(bad), 16'h0);
        send(OP_MUL, 16'h0003, 16'h0004, mk(16'h000C, 1'b1, 1'b0, 5'b10110), 1'b0);
        bus.I_ready = 1'b0;
        repeat (5) @(posedge I_clk);
        #1;
`else
        send(OP_MUL, 16'h0003, 16'h0004, mk(16'h0000, 1'b0, 1'b1, 5'b10110), 1'b1);
        send(OP_ADD, 16'h0005, 16'h0005, mk(16'h000A, 1'b1, 1'b0, 5'b00110), 1'b0);
        bus.I_ready = 1'b0;
`endif

        // Reset with work in flight: everything discarded, PSR cleared.
        I_rst = 1'b1;
        @(posedge I_clk);
        #1 I_rst = 1'b0;
        bus.I_ready = 1'b1;
        chk("rst2_valid", 16'(bus.O_valid), 16'h0);
        chk("rst2_dest",  bus.O_dest,       16'h0000);
        chk("rst2_flags", 16'(bus.O_flags), 16'h0);
        chk("rst2_ready", 16'(bus.O_ready), 16'h1);
        repeat (20) @(posedge I_clk);
        #1;
        chk("rst2_no_late_result", 16'(bus.O_valid), 16'h0);
        op(OP_ADD, 16'h0001, 16'h0001, 16'h0002, 5'b00000);

        repeat (3) @(posedge I_clk);
        chk("scoreboard_empty", 16'(sb.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cr16_alu_exec.md
Name: cr16_alu_exec

Overview:
Registered execute stage for the CR16 datapath, acting as the responder to an ALU operation requester. It accepts one operation per valid/ready handshake and registers the 16-bit result together with write-back and illegal-opcode qualifiers. It owns the processor status flags (PSR) and presents a valid/ready result interface to the write-back stage. Single-cycle ops sustain one op per clock; the optional multiply is iterative.

Parameters:
DATA_WIDTH, 16, operand/result width. Only 16 is supported.
PSR_RESET, 5'b00000, PSR value after reset.

Ports:
I_clk  input  1  clock; all state changes on rising edge
I_rst  input  1  synchronous active-high reset
I_valid  input  1  request valid
O_ready  output  1  request ready; accept = I_valid && O_ready
I_opcode  input  4  operation select
I_op1  input  16  destination operand (Rdest)
I_op2  input  16  source operand (Rsrc/immediate)
O_valid  output  1  result valid
I_ready  input  1  downstream ready; retire = O_valid && I_ready
O_dest  output  16  registered result
O_wb  output  1  result is to be written to the register file
O_illegal  output  1  result slot came from an unknown opcode
O_flags  output  5  current PSR {C,L,F,Z,N} = bits [4:0]

Behaviour:
- Reset (I_rst=1 at edge, takes priority over everything): O_valid=0, O_dest=0, O_wb=0, O_illegal=0, PSR=PSR_RESET, FSM=IDLE. An in-flight multiply is discarded.
- FSM states: IDLE, MUL_BUSY (MUL_BUSY exists only with the macro).
- O_ready = (state==IDLE) && (!O_valid || I_ready). O_ready depends combinationally on I_ready; nothing else is combinational to outputs.
- On accept of a non-MUL op: O_dest, O_wb, O_illegal and PSR update at that same edge, and O_valid=1. Latency is 1 cycle.
- Simultaneous retire and accept: the output register is overwritten and O_valid stays 1. Retire without accept: O_valid goes to 0.
- While O_valid=1 && I_ready=0, O_dest, O_wb and O_illegal hold stable.
- PSR updates at the accept edge, so a back-to-back ADDC/SUBC sees the carry from the preceding op.
- Opcodes, 16-bit wraparound arithmetic (flags not listed are unchanged):
  - 0 ADD: C=unsigned carry out, F=signed overflow.
  - 1 ADDU: C only.
  - 2 ADDC: op1+op2+PSR.C; C and F.
  - 3 SUB: op1-op2; C=borrow (op1 <u op2), F=signed overflow.
  - 4 SUBC: op1-op2-PSR.C; C and F.
  - 5 CMP: O_wb=0; Z=(op1==op2), L=(op1 <u op2), N=(op1 <s op2); O_dest=0.
  - 6 AND, 7 OR, 8 XOR: no flags.
  - 9 MOV: result=op2.
  - A LSH: shift amount s=op2[4:0] as signed. s>0 shifts op1 left logical by s; s<0 shifts right logical by -s; s=-16 gives 0.
  - B ASHU: as LSH, but right shifts are arithmetic; s=-16 gives 16{op1[15]}.
  - C LUI: result={op2[7:0],8'h00}.
  - D MUL: see Optional Feature.
  - E, F: illegal. O_dest=0, O_wb=0, O_illegal=1, PSR unchanged; the op still completes with latency 1.
- O_wb=1 for every legal op except CMP.

Optional Feature:
- Macro: CR16_ALU_MUL_EN.
- Defined:
  - Opcode D is accepted and the FSM enters MUL_BUSY with O_ready=0.
  - An unsigned shift-add runs for 16 cycles over 16x16 operands, producing the low 16 bits.
  - On the edge 17 cycles after accept, O_valid=1, O_dest=product, O_wb=1. PSR is unchanged. The FSM returns to IDLE.
  - The pending output must retire before MUL completes. MUL is accepted only when O_ready=1, which guarantees this.
- Undefined: opcode D is treated as illegal, and MUL_BUSY and the multiplier are absent.

Decomposition:
- Shared header cr16_defs.vh holds:
  - opcode localparams (OP_ADD..OP_MUL);
  - flag bit indices (FLAG_C=4, FLAG_L=3, FLAG_F=2, FLAG_Z=1, FLAG_N=0);
  - FSM state encodings.
- Sub-module cr16_mul_seq: iterative multiplier with start/done and 16-bit product, instantiated only under CR16_ALU_MUL_EN.

Test Plan:
1. ADD 0x7FFF+0x0001 after reset: O_valid=1 one cycle later, O_dest=0x8000, F=1, C=0, O_wb=1.
2. ADD 0xFFFF+0x0001 then ADDC 0x0001+0x0001 back-to-back: results 0x0000 (C=1) then 0x0003 (C=0).
3. CMP op1=0x0005, op2=0xFFFB: O_wb=0, Z=0, L=1, N=0; then CMP 0x1234, 0x1234 gives Z=1, L=0, N=0.
4. Backpressure: hold I_ready=0 with O_valid=1 and I_valid=1; O_ready=0 and O_dest stays stable for 5 cycles. Raise I_ready, then stream 4 ADDs with 1 result per cycle, none lost or duplicated.
5. Shifts:
   - LSH 0x0001 by 0x000F gives 0x8000.
   - LSH 0x8000 by 0x001F gives 0x4000.
   - ASHU 0x8000 by 0x0011 gives 0xFFFF.
   - LSH 0xFFFF by 0x0010 gives 0x0000.
   - Opcode F gives O_illegal=1 with PSR unchanged.
6. Multiply, with CR16_ALU_MUL_EN:
   - MUL 0x0012*0x0034 gives O_dest=0x03A8 exactly 17 cycles after accept, with O_ready=0 meanwhile.
   - Assert I_rst 5 cycles into a second MUL: O_valid=0, FSM=IDLE, PSR=0.
